// File: rtl/ram_io_pkg.sv
// Memory-interface constants shared by ram_io and the CPU: access-size encodings,
// lane geometry and the ram_io controller state type.
package ram_io_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_RESP      = 2'd2
  } ram_io_state_e;

  // Misaligned accesses and the reserved size are rejected before touching RAM.
  function automatic logic access_error(input mem_size_e size, input logic [1:0] offset);
    logic err;
    err = 1'b0;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = offset[0];
      SIZE_WORD: err = |offset;
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/ram_io_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a RAM word and
// right-aligns it with zero or sign extension.
module ram_io_load_align
  import ram_io_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  mem_size_e   size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {offset_i, 3'b000};

  always_comb begin
    result_o = shifted;
    case (size_i)
      SIZE_BYTE: result_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default:   result_o = shifted;
    endcase
  end

endmodule

// File: rtl/ram_io.sv
// Load/store front end for a single-port RAM with registered reads: accepts one
// request at a time, drives byte-lane writes, and returns a one-cycle response.
module ram_io
  import ram_io_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [NUM_LANES-1:0]  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  ram_io_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [1:0]            off_q, off_d;
  mem_size_e             size_q, size_d;
  logic                  signed_q, signed_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  mem_size_e             req_size_e;
  logic                  req_err;
  logic                  accept;
  logic [NUM_LANES-1:0]  lane_be;
  logic [DATA_WIDTH-1:0] lane_din;
  logic [31:0]           load_result;

  assign req_size_e = mem_size_e'(req_size);
  assign req_err    = access_error(req_size_e, req_addr[1:0]);
  assign accept     = req_valid & req_ready;

  // Per-lane enable and replicated store data; the enable picks which copy lands.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_be[gi] = (req_size_e == SIZE_WORD)
                       | ((req_size_e == SIZE_HALF) & (req_addr[1] == LANE[1]))
                       | ((req_size_e == SIZE_BYTE) & (req_addr[1:0] == LANE));
    assign lane_din[LANE_W*gi +: LANE_W] =
        (req_size_e == SIZE_BYTE) ? req_wdata[7:0] :
        (req_size_e == SIZE_HALF) ? req_wdata[LANE_W*(gi%2) +: LANE_W] :
                                    req_wdata[LANE_W*gi +: LANE_W];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (req_write || req_err) ? ST_RESP : ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs: RAM port A is driven straight from the request while idle.
  always_comb begin
    req_ready = (state_q == ST_IDLE) & ~rst;
    ram_we    = '0;
    ram_addr  = waddr_q;
    ram_din   = lane_din;
    if (state_q == ST_IDLE) begin
      ram_addr = req_addr[ADDR_WIDTH+1:2];
      if (accept && req_write && !req_err) begin
        ram_we = lane_be;
      end
    end
  end

  // Request latch
  always_comb begin
    waddr_d  = waddr_q;
    off_d    = off_q;
    size_d   = size_q;
    signed_d = signed_q;
    if (accept) begin
      waddr_d  = req_addr[ADDR_WIDTH+1:2];
      off_d    = req_addr[1:0];
      size_d   = req_size_e;
      signed_d = req_signed;
    end
  end

  ram_io_load_align u_load_align (
    .word_i   (ram_dout),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .result_o (load_result)
  );

  // Response: defaults to zero so everything clears as RESP is left.
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (req_write || req_err)) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = req_err;
        end
      end
      ST_READ_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_result;
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q     <= '0;
      off_q       <= '0;
      size_q      <= SIZE_BYTE;
      signed_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      waddr_q     <= waddr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_io.sv
// Bench for ram_io: attached RAM plus a byte-addressed reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ram_io;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_signed;
  logic [1:0]    req_size;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_error;
  logic [31:0]   rsp_rdata;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din, ram_dout;

  always #5 clk = ~clk;

  ram_io #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Attached RAM: byte-write port A, registered read-first output.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (ram_we[l]) ram[ram_addr][8*l +: 8] <= ram_din[8*l +: 8];
    end
    ram_dout <= ram[ram_addr];
  end

  // Reference model: flat byte memory and a queue of due responses.
  logic [7:0] byte_mem [0:(1<<(AW+2))-1];
  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t pend[$];

  int cyc = 0;
  int next_free = 0;
  int dut_rsp_cnt = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_accept();
    int n, a;
    logic err;
    logic [3:0] we;
    logic [31:0] v;
    rsp_t r;
    a   = int'(req_addr);
    n   = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
    err = (req_size == 2'd3) || ((a % n) != 0);
    we  = '0;
    if (req_write && !err) begin
      for (int i = 0; i < n; i++) we[(a + i) % 4] = 1'b1;
    end
    chk("ram_we", 32'(ram_we), 32'(we));
    if (req_write && !err) begin
      for (int i = 0; i < n; i++) begin
        chk("ram_din_lane", 32'(ram_din[8*((a + i) % 4) +: 8]), 32'(req_wdata[8*i +: 8]));
        byte_mem[a + i] = req_wdata[8*i +: 8];
      end
    end
    v = '0;
    if (!req_write && !err) begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = byte_mem[a + i];
      if (req_signed && n < 4 && v[8*n - 1]) begin
        for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      end
    end
    r.due   = cyc + ((req_write || err) ? 1 : 2);
    r.rdata = v;
    r.err   = err;
    pend.push_back(r);
    next_free = cyc + ((req_write || err) ? 2 : 3);
  endtask

  // Compare process: every negedge, DUT outputs against the model.
  initial begin
    logic m_ready, exp_v;
    forever begin
      @(negedge clk);
      m_ready = !rst && (cyc >= next_free);
      exp_v   = (pend.size() > 0) && (pend[0].due == cyc);
      if (rsp_valid) dut_rsp_cnt++;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rsp_rdata", rsp_rdata, pend[0].rdata);
        chk("rsp_error", 32'(rsp_error), 32'(pend[0].err));
        $display("rsp cycle %0d: rdata=0x%08h error=%0b", cyc, rsp_rdata, rsp_error);
        void'(pend.pop_front());
      end else begin
        chk("rsp_rdata_idle", rsp_rdata, 32'h0);
        chk("rsp_error_idle", 32'(rsp_error), 32'h0);
      end
      chk("req_ready", 32'(req_ready), 32'(m_ready));
      if (rst) begin
        pend.delete();
        next_free = cyc + 1;
        chk("ram_we_rst", 32'(ram_we), 32'h0);
      end else if (m_ready && req_valid) begin
        model_accept();
      end else begin
        chk("ram_we_noacc", 32'(ram_we), 32'h0);
      end
      if (m_ready) chk("ram_addr", 32'(ram_addr), 32'(req_addr[AW+1:2]));
    end
  end

  task automatic do_req(input string name, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [AW+1:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [3:0] we);
    int n, c0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    chk({name, " accept"}, 32'(req_ready), 32'h1);
    we = ram_we;
    c0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = (AW+2)'($urandom); req_wdata = $urandom;
    rd = '0; er = 1'b0; lat = -1; n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (rsp_valid) begin lat = cyc - c0; rd = rsp_rdata; er = rsp_error; break; end
      n++;
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL %s: no response within 10 cycles, expected one", name);
    end
    $display("txn %s: we=%b rdata=0x%08h error=%0b latency=%0d", name, we, rd, er, lat);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [3:0]  we;
  logic [31:0] exp_sb [4] = '{32'hFFFF_FFF3, 32'hFFFF_FF82, 32'hFFFF_FF81, 32'hFFFF_FF80};

  logic        bw [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0]  bs [6] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [13:0] ba [6] = '{14'h004, 14'h010, 14'h010, 14'h011, 14'h012, 14'h010};
  logic [31:0] bd [6] = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'h55, 32'h1234, 32'h0};
  int          exp_sp [5] = '{3, 2, 3, 2, 2};

  initial begin
    int acc [6];
    int n, r0;
    for (int i = 0; i < (1<<AW); i++) ram[i] = 32'h0;
    for (int i = 0; i < (1<<(AW+2)); i++) byte_mem[i] = 8'h0;
    ram[0] = 32'h8081_82F3;
    byte_mem[0] = 8'hF3; byte_mem[1] = 8'h82; byte_mem[2] = 8'h81; byte_mem[3] = 8'h80;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_req("st_word_004", 1'b1, 2'd2, 1'b0, 14'h004, 32'h1122_3344, rd, er, lat, we);
    chk("st_word_004 we", 32'(we), 32'hF);
    chk("st_word_004 lat", 32'(lat), 32'd1);
    chk("st_word_004 err", 32'(er), 32'h0);
    do_req("ld_word_004", 1'b0, 2'd2, 1'b0, 14'h004, 32'h0, rd, er, lat, we);
    chk("ld_word_004 data", rd, 32'h1122_3344);
    chk("ld_word_004 lat", 32'(lat), 32'd2);

    for (int i = 0; i < 4; i++) begin
      do_req("ld_sbyte", 1'b0, 2'd0, 1'b1, 14'(i), 32'h0, rd, er, lat, we);
      chk("ld_sbyte data", rd, exp_sb[i]);
    end
    do_req("ld_ubyte_001", 1'b0, 2'd0, 1'b0, 14'h001, 32'h0, rd, er, lat, we);
    chk("ld_ubyte_001 data", rd, 32'h0000_0082);

    do_req("st_half_00a", 1'b1, 2'd1, 1'b0, 14'h00A, 32'h0000_BEEF, rd, er, lat, we);
    chk("st_half_00a we", 32'(we), 32'hC);
    do_req("ld_word_008", 1'b0, 2'd2, 1'b0, 14'h008, 32'h0, rd, er, lat, we);
    chk("ld_word_008 data", rd, 32'hBEEF_0000);
    do_req("ld_shalf_00a", 1'b0, 2'd1, 1'b1, 14'h00A, 32'h0, rd, er, lat, we);
    chk("ld_shalf_00a data", rd, 32'hFFFF_BEEF);

    do_req("err_ld_word_002", 1'b0, 2'd2, 1'b0, 14'h002, 32'h0, rd, er, lat, we);
    chk("err_ld_word_002 err", 32'(er), 32'h1);
    chk("err_ld_word_002 lat", 32'(lat), 32'd1);
    chk("err_ld_word_002 data", rd, 32'h0);
    do_req("err_st_half_003", 1'b1, 2'd1, 1'b0, 14'h003, 32'h0000_DEAD, rd, er, lat, we);
    chk("err_st_half_003 err", 32'(er), 32'h1);
    chk("err_st_half_003 we", 32'(we), 32'h0);
    do_req("err_st_size3", 1'b1, 2'd3, 1'b0, 14'h000, 32'hFFFF_FFFF, rd, er, lat, we);
    chk("err_st_size3 err", 32'(er), 32'h1);
    chk("err_st_size3 we", 32'(we), 32'h0);
    do_req("ld_word_000", 1'b0, 2'd2, 1'b0, 14'h000, 32'h0, rd, er, lat, we);
    chk("ld_word_000 unchanged", rd, 32'h8081_82F3);

    // Back-to-back with req_valid held high.
    r0 = dut_rsp_cnt;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_write = bw[i]; req_size = bs[i]; req_signed = 1'b0;
      req_addr = ba[i]; req_wdata = bd[i];
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 20);
      chk("b2b accept", 32'(req_ready), 32'h1);
      acc[i] = cyc;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 1; i < 6; i++) chk("b2b spacing", 32'(acc[i] - acc[i-1]), 32'(exp_sp[i-1]));
    chk("b2b rsp count", 32'(dut_rsp_cnt - r0), 32'd6);
    $display("txn b2b: 6 requests accepted at cycles %0d %0d %0d %0d %0d %0d",
             acc[0], acc[1], acc[2], acc[3], acc[4], acc[5]);
    do_req("ld_word_010", 1'b0, 2'd2, 1'b0, 14'h010, 32'h0, rd, er, lat, we);
    chk("ld_word_010 data", rd, 32'h1234_550D);

    // Reset in the cycle after a load accept.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 14'h000;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    r0 = dut_rsp_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst req_ready", 32'(req_ready), 32'h1);
    repeat (3) @(negedge clk);
    chk("rst dropped rsp", 32'(dut_rsp_cnt - r0), 32'h0);
    $display("txn rst_drop: load dropped by reset");
    @(posedge clk); #1;
    do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 14'h000, 32'h0, rd, er, lat, we);
    chk("ld_after_rst data", rd, 32'h8081_82F3);
    chk("ld_after_rst lat", 32'(lat), 32'd2);

    // Random traffic, including ignored inputs while busy and occasional reset.
    for (int t = 0; t < 3000; t++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = 14'($urandom_range(0, 63));
      req_wdata  = $urandom;
      @(posedge clk); #1;
    end
    rst = 1'b0; req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion by 1000000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_io.md
RAM_IO -- requirements
Module: ram_io

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: word-address width of the attached RAM; byte address is ADDR_WIDTH+2 bits.
REQ-002 Parameter DATA_WIDTH, fixed 32: RAM word width; 4 byte lanes of 8 bits.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 req_signed  in  1  sign-extend loaded byte/halfword (ignored for stores and words).
REQ-010 req_addr  in  ADDR_WIDTH+2  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-014 rsp_error  out  1  request rejected (misaligned or reserved size); qualified by rsp_valid.
REQ-015 ram_we  out  4  per-byte write enable to RAM port A.
REQ-016 ram_addr  out  ADDR_WIDTH  word address to RAM port A.
REQ-017 ram_din  out  32  write data to RAM port A.
REQ-018 ram_dout  in  32  RAM port A registered read data (1-cycle latency).

Function
REQ-019 FSM states: IDLE, READ_WAIT, RESP; req_ready = (state == IDLE) and not rst.
REQ-020 Accept occurs at edge k where req_valid and req_ready are both high; request fields are latched at k.
REQ-021 In IDLE, ram_addr = req_addr[ADDR_WIDTH+1:2] combinationally; in other states it holds the latched word address.
REQ-022 Error check: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11 is an error; errored requests never assert ram_we.
REQ-023 Store, no error: ram_we asserted combinationally in IDLE during the accept cycle only; byte -> 1<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111.
REQ-024 Store data replication: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
REQ-025 ram_we SHALL be 0 in every state other than IDLE and whenever rst is high.
REQ-026 Store or any error: IDLE -> RESP at k; rsp_valid high in cycle k+1, rsp_rdata = 0, rsp_error per REQ-022.
REQ-027 Load, no error: IDLE -> READ_WAIT at k; at edge k+1 ram_dout is shifted right by 8*addr[1:0], masked to size, and zero/sign-extended per req_signed into rsp_rdata; READ_WAIT -> RESP.
REQ-028 Load rsp_valid is high in cycle k+2 only; rsp_error = 0.
REQ-029 RESP -> IDLE unconditionally; rsp_valid, rsp_error, rsp_rdata are registered and cleared when leaving RESP.
REQ-030 Response has no backpressure; minimum request spacing is 2 cycles for stores/errors and 3 cycles for loads.
REQ-031 req_* inputs are ignored outside the accept cycle.

Reset
REQ-032 Reset forces state IDLE, rsp_valid 0, rsp_error 0, rsp_rdata 0, latched request 0, and ram_we 0 in the same cycle.
REQ-033 Reset during READ_WAIT or RESP drops the request without a response; a store accepted at the reset edge is not written.

Structure
REQ-034 Size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) go in the shared memory-interface constants package, which the CPU also uses.
REQ-035 Load alignment and extension is a combinational sub-module, ram_io_load_align (inputs word, offset, size, signed; output 32-bit result).
REQ-036 The FSM, store lane and byte-enable generation, and error check reside in ram_io.

Verification (bench with the RAM model, ADDR_WIDTH 12, memory preloaded with word 0 = 0x8081_82F3)
REQ-037 Word store to addr 0x004 with data 0x1122_3344 -> ram_we 1111 in the accept cycle, rsp_valid at k+1, error 0; a word load of 0x004 returns 0x1122_3344 at k+2.
REQ-038 Signed byte loads of addr 0x000..0x003 -> 0xFFFF_FFF3, 0xFFFF_FF82, 0xFFFF_FF81, 0xFFFF_FF80; unsigned load of 0x001 -> 0x0000_0082.
REQ-039 Halfword store 0xBEEF to 0x00A, then word load of 0x008 with prior word 0 -> ram_we 1100; result 0xBEEF_0000; signed half load of 0x00A -> 0xFFFF_BEEF.
REQ-040 Word load of 0x002, half store to 0x003, and size 11 -> rsp_error 1 at k+1, rsp_rdata 0, ram_we never asserted, memory unchanged.
REQ-041 Back-to-back requests with req_valid held high -> req_ready low in READ_WAIT/RESP, no request lost or duplicated, accepts spaced 3 cycles (load) and 2 cycles (store).
REQ-042 rst asserted in the cycle after a load accept -> no rsp_valid; req_ready high the cycle after rst deasserts; the next load completes normally.
